// File: rtl/uart_tx_arbiter_if.sv
// Request/grant bundle between four requesters and the UART transmit arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface uart_tx_arbiter_if;
  logic [3:0]  i_req;
  logic [27:0] i_data;
  logic [3:0]  o_ack;
  logic [1:0]  o_grant_id;
  logic        o_tx_start_n;
  logic [8:0]  o_tx_data;
  logic        o_busy;

  modport master (
    output i_req, i_data,
    input  o_ack, o_grant_id, o_tx_start_n, o_tx_data, o_busy
  );

  modport slave (
    input  i_req, i_data,
    output o_ack, o_grant_id, o_tx_start_n, o_tx_data, o_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of four requesters a UART transmitter frame.
// Optional even parity in o_tx_data[8] is built when UART_ARB_PARITY_EN is defined.
module uart_tx_arbiter #(
  parameter int FRAME_CYCLES = 10,
  parameter int GAP_CYCLES   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int MAX_CYC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [1:0]       rr_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       ack_r;
  logic [1:0]       grant_id_r;
  logic             tx_start_n_r;
  logic [8:0]       tx_data_r;
  logic             busy_r;

  logic [2:0]       pick_s;
  logic             found_s;
  logic [1:0]       win_id_s;
  logic [6:0]       win_char_s;
  logic             par_s;

  // Returns {found, id}; scanning offsets downward lets the smallest offset from ptr win.
  function automatic logic [2:0] pick_winner(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef UART_ARB_PARITY_EN
  function automatic logic even_parity7(input logic [6:0] d);
    return ^d;
  endfunction

  assign par_s = even_parity7(win_char_s);
`else
  assign par_s = 1'b0;
`endif

  assign pick_s     = pick_winner(bus.i_req, rr_ptr_r);
  assign found_s    = pick_s[2];
  assign win_id_s   = pick_s[1:0];
  assign win_char_s = bus.i_data[{3'b000, win_id_s} * 5'd7 +: 7];

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= 2'd0;
      cnt_r        <= CNT_W'(0);
      ack_r        <= 4'b0000;
      grant_id_r   <= 2'd0;
      tx_start_n_r <= 1'b1;
      tx_data_r    <= 9'h000;
      busy_r       <= 1'b0;
    end else begin
      ack_r        <= 4'b0000;
      tx_start_n_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r      <= ST_LOAD;
            ack_r        <= 4'b0001 << win_id_s;
            tx_start_n_r <= 1'b0;
            grant_id_r   <= win_id_s;
            rr_ptr_r     <= win_id_s + 2'd1;
            tx_data_r    <= {par_s, 1'b0, win_char_s};
            busy_r       <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_r <= ST_SEND;
          cnt_r   <= FRAME_LOAD;
          busy_r  <= 1'b1;
        end
        ST_SEND: begin
          if (cnt_r == CNT_W'(0)) begin
            if (GAP_CYCLES == 0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_GAP;
              cnt_r   <= GAP_LOAD;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_r == CNT_W'(0)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_W'(0);
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ack        = ack_r;
  assign bus.o_grant_id   = grant_id_r;
  assign bus.o_tx_start_n = tx_start_n_r;
  assign bus.o_tx_data    = tx_data_r;
  assign bus.o_busy       = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_uart_tx_arbiter;
  localparam int FRAME = 10;
  localparam int GAP   = 2;
  localparam int SPAN  = FRAME + GAP;

  logic clk = 1'b0;
  logic rst;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc = 0;
  int busy_total = 0;
  int strobe_total = 0;
  int log_id[$];
  int log_cyc[$];

  // Model: a transaction is a grant time plus a phase count; phases 0..SPAN are busy.
  bit         m_active;
  int         m_phase;
  int         m_ptr;
  int         m_grant;
  logic [8:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_step();
    bit found;
    int k;
    logic [6:0] ch;
    if (rst) begin
      m_active = 0; m_phase = 0; m_ptr = 0; m_grant = 0; m_data = 9'h000;
    end else if (!m_active) begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (!found && bus.i_req[k]) begin
          found = 1;
          m_grant = k;
        end
      end
      if (found) begin
        ch = bus.i_data[7*m_grant +: 7];
`ifdef UART_ARB_PARITY_EN
        m_data = {($countones(ch) % 2 == 1) ? 1'b1 : 1'b0, 1'b0, ch};
`else
        m_data = {2'b00, ch};
`endif
        m_ptr    = (m_grant + 1) % 4;
        m_active = 1;
        m_phase  = 0;
      end
    end else begin
      m_phase++;
      if (m_phase > SPAN) m_active = 0;
    end
  endtask

  task automatic compare();
    logic [3:0] exp_ack;
    exp_ack = (m_active && m_phase == 0) ? (4'b0001 << m_grant) : 4'b0000;
    chk("busy",     bus.o_busy,       m_active);
    chk("start_n",  bus.o_tx_start_n, !(m_active && m_phase == 0));
    chk("ack",      bus.o_ack,        exp_ack);
    chk("grant_id", bus.o_grant_id,   m_grant);
    chk("tx_data",  bus.o_tx_data,    m_data);
    if (bus.o_busy) busy_total++;
    if (!bus.o_tx_start_n) begin
      strobe_total++;
      log_id.push_back(int'(bus.o_grant_id));
      log_cyc.push_back(cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b0, s0, l0;
    rst = 1'b1;
    bus.i_req  = 4'b0000;
    bus.i_data = 28'h0000000;
    fork
      begin
        forever begin
          @(posedge clk);
          cyc++;
          model_step();
          #1;
          compare();
        end
      end
      begin
        // Reset state
        step(3);
        chk("rst_busy",    bus.o_busy,       1'b0);
        chk("rst_start_n", bus.o_tx_start_n, 1'b1);
        chk("rst_tx_data", bus.o_tx_data,    9'h000);
        chk("rst_ack",     bus.o_ack,        4'b0000);
        chk("rst_grant",   bus.o_grant_id,   2'd0);
        rst = 1'b0;
        step(1);

        // Single request
        bus.i_data[6:0] = 7'h41;
        b0 = busy_total; s0 = strobe_total;
        bus.i_req = 4'b0001;
        step(1);
        chk("t1_tx_data", bus.o_tx_data,    9'h041);
        chk("t1_ack",     bus.o_ack,        4'b0001);
        chk("t1_start_n", bus.o_tx_start_n, 1'b0);
        bus.i_req = 4'b0000;
        step(1);
        chk("t1_start_n_after", bus.o_tx_start_n, 1'b1);
        step(20);
        chk("t1_busy_cycles", busy_total - b0,   13);
        chk("t1_strobes",     strobe_total - s0, 1);

        // All four held, pointer starting at 0
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        bus.i_data = {7'h74, 7'h63, 7'h52, 7'h41};
        l0 = log_id.size();
        bus.i_req = 4'b1111;
        step(57);
        bus.i_req = 4'b0000;
        step(20);
        chk("t2_count", log_id.size() - l0, 5);
        if (log_id.size() - l0 == 5) begin
          chk("t2_g0", log_id[l0],   0);
          chk("t2_g1", log_id[l0+1], 1);
          chk("t2_g2", log_id[l0+2], 2);
          chk("t2_g3", log_id[l0+3], 3);
          chk("t2_g4", log_id[l0+4], 0);
          for (int i = 1; i < 5; i++)
            chk("t2_spacing", log_cyc[l0+i] - log_cyc[l0+i-1], 14);
        end

        // Pointer wrap: grant 2, then 0101 must go to 0
        bus.i_req = 4'b0100;
        step(1);
        chk("t3_grant2", bus.o_grant_id, 2'd2);
        bus.i_req = 4'b0000;
        step(20);
        bus.i_req = 4'b0101;
        step(1);
        chk("t3_grant0", bus.o_grant_id, 2'd0);
        chk("t3_ack0",   bus.o_ack,      4'b0001);
        bus.i_req = 4'b0000;
        step(20);

        // Reset in the fifth SEND cycle
        bus.i_req = 4'b0010;
        step(1);
        bus.i_req = 4'b0000;
        step(5);
        chk("t4_busy_pre", bus.o_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("t4_busy",    bus.o_busy,       1'b0);
        chk("t4_start_n", bus.o_tx_start_n, 1'b1);
        chk("t4_ack",     bus.o_ack,        4'b0000);
        chk("t4_tx_data", bus.o_tx_data,    9'h000);
        step(2);
        rst = 1'b0;
        bus.i_req = 4'b1000;
        step(1);
        chk("t4_grant3", bus.o_grant_id, 2'd3);
        chk("t4_data3",  bus.o_tx_data,  9'h074);
        bus.i_req = 4'b0000;
        step(20);

        // Request dropped during SEND
        bus.i_req = 4'b0011;
        step(1);
        chk("t5_ack", bus.o_ack, 4'b0001);
        bus.i_req = 4'b0010;
        step(5);
        bus.i_req = 4'b0000;
        l0 = log_id.size();
        step(25);
        chk("t5_no_strobe", log_id.size() - l0, 0);
        chk("t5_idle",      bus.o_busy,         1'b0);

        // Parity bit
        bus.i_data[6:0] = 7'h07;
        bus.i_req = 4'b0001;
        step(1);
        bus.i_req = 4'b0000;
`ifdef UART_ARB_PARITY_EN
        chk("t6_par07", bus.o_tx_data, 9'h107);
`else
        chk("t6_par07", bus.o_tx_data, 9'h007);
`endif
        step(20);
        bus.i_data[6:0] = 7'h03;
        bus.i_req = 4'b0001;
        step(1);
        bus.i_req = 4'b0000;
        chk("t6_par03", bus.o_tx_data, 9'h003);
        step(20);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
